// File: rtl/skinny_masking_pkg.sv
// Shared definitions for the masked Skinny S-box front end: FSM states, LFSR
// constants and an unmasked S-box reference.
package skinny_masking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_RUN   = 3'd2,
        ST_CAPT  = 3'd3,
        ST_DONE  = 3'd4
    } drv_state_e;

    // Taps of x^16+x^14+x^13+x^11+1 seen from the shift-out end (bits 0,2,3,5).
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    function automatic logic [3:0] sbox_ref(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h6;
            4'h2: y = 4'h9;
            4'h3: y = 4'h0;
            4'h4: y = 4'h1;
            4'h5: y = 4'hA;
            4'h6: y = 4'h2;
            4'h7: y = 4'hB;
            4'h8: y = 4'h3;
            4'h9: y = 4'h8;
            4'hA: y = 4'h5;
            4'hB: y = 4'hD;
            4'hC: y = 4'h4;
            4'hD: y = 4'hE;
            4'hE: y = 4'h7;
            4'hF: y = 4'hF;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/share_lfsr16.sv
// 16-bit Fibonacci LFSR supplying the input mask and the per-cycle fresh
// randomness; a zero seed would lock the register, so it falls back to SEED.
module share_lfsr16
    import skinny_masking_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [3:0]  mask,
    output logic [3:0]  fresh
);

    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nxt_s;

    // Next LFSR value: seed load or one shift step.
    always_comb begin
        lfsr_nxt_s = lfsr_step(lfsr_r);
        if (load) begin
            if (seed == 16'h0000) begin
                lfsr_nxt_s = SEED;
            end else begin
                lfsr_nxt_s = seed;
            end
        end else begin
            lfsr_nxt_s = lfsr_step(lfsr_r);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end

    // Mask and fresh come from disjoint bit fields.
    assign mask  = lfsr_r[3:0];
    assign fresh = lfsr_r[11:8];

endmodule

// File: rtl/skinny_sbox_share_driver.sv
// Two-share masking front end for the Skinny 4-bit S-box: splits the input
// nibble, paces launch/capture on Synch and recombines the output shares.
module skinny_sbox_share_driver
    import skinny_masking_pkg::*;
#(
    parameter int          LATENCY = 5,
    parameter logic [15:0] SEED    = DEFAULT_SEED,
    parameter int          TIMEOUT = 2 * LATENCY + 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_data,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [3:0]  X_s0,
    output logic [3:0]  X_s1,
    output logic [3:0]  Fresh,
    input  logic [3:0]  Y_s0,
    input  logic [3:0]  Y_s1,
    input  logic        Synch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_data,
    output logic        busy,
    output logic        timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    drv_state_e       state_r;
    drv_state_e       state_nxt_s;
    logic             accept_s;
    logic             abort_s;
    logic             lfsr_load_s;
    logic             timeout_hit_s;
    logic [3:0]       mask_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       x_s0_r;
    logic [3:0]       x_s1_r;
    logic [3:0]       out_data_r;
    logic             out_valid_r;
    logic             timeout_err_r;
    logic             busy_r;

    assign lfsr_load_s   = seed_load && (state_r == ST_IDLE);
    assign timeout_hit_s = (cnt_r == CNT_LAST);

    share_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst),
        .load  (lfsr_load_s),
        .seed  (seed),
        .mask  (mask_s),
        .fresh (Fresh)
    );

    // Next-state and handshake decode; seed loading blocks acceptance.
    always_comb begin
        state_nxt_s = state_r;
        in_ready    = 1'b0;
        accept_s    = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = ~seed_load;
                if (in_valid && !seed_load) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_ALIGN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (timeout_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (Synch) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_ALIGN;
                end
            end
            ST_RUN: begin
                if (timeout_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (Synch) begin
                    state_nxt_s = ST_CAPT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_CAPT: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with busy registered alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Watchdog counter over the ALIGN/RUN wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= '0;
        end else if (state_r == ST_ALIGN || state_r == ST_RUN) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Input shares: launched on accept, wiped once the result is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_s0_r <= 4'h0;
            x_s1_r <= 4'h0;
        end else if (accept_s) begin
            x_s1_r <= mask_s;
            x_s0_r <= in_data ^ mask_s;
        end else if (state_r == ST_CAPT || abort_s) begin
            x_s0_r <= 4'h0;
            x_s1_r <= 4'h0;
        end
    end

    // Result register; shares meet only in CAPT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_r    <= 4'h0;
            out_valid_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else if (state_r == ST_CAPT) begin
            out_data_r  <= Y_s0 ^ Y_s1;
            out_valid_r <= 1'b1;
        end else if (abort_s) begin
            out_data_r    <= 4'h0;
            out_valid_r   <= 1'b1;
            timeout_err_r <= 1'b1;
        end else if (state_r == ST_DONE && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign X_s0        = x_s0_r;
    assign X_s1        = x_s1_r;
    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: doc/skinny_sbox_share_driver.md
Name: skinny_sbox_share_driver

Overview:
- Initiator side of the masked Skinny 4-bit S-box interface with first-order HPC2 gadgets and clock gating.
- Accepts an unmasked nibble over a valid/ready handshake and splits it into two Boolean shares using an internal LFSR.
- While the S-box computes, supplies fresh randomness every cycle, aligns launch and capture to the S-box Synch pulse, then recombines the output shares.
- Sits between an unmasked test/control datapath and the masked S-box instance, which has LATENCY = 5.

Parameters:
- LATENCY, 5, period in clk cycles of the S-box clock-gating controller (Synch spacing).
- SEED, 16'hACE1, LFSR reset value; must be non-zero.
- TIMEOUT, 2*LATENCY+2, maximum cycles spent in ALIGN+RUN before the driver aborts.

Ports:
- clk  in  1  single system clock, shared with the S-box.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input nibble valid.
- in_ready  out  1  driver can accept a nibble.
- in_data  in  4  unmasked S-box input.
- seed_load  in  1  load seed into the LFSR (honoured in IDLE only).
- seed  in  16  LFSR seed value.
- X_s0  out  4  share 0 of the S-box input.
- X_s1  out  4  share 1 of the S-box input.
- Fresh  out  4  per-cycle fresh randomness to the S-box.
- Y_s0  in  4  share 0 of the S-box output.
- Y_s1  in  4  share 1 of the S-box output.
- Synch  in  1  S-box window-boundary pulse.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  4  unmasked result, Y_s0^Y_s1.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky flag: a Synch pulse was missed.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, lfsr=SEED.
  - X_s0=X_s1=0, out_data=0, out_valid=0, timeout_err=0, busy=0.
  - in_ready=1 once rst deasserts.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances one step every cycle in every state.
  - Fresh = lfsr[11:8] combinationally, so it is new each cycle.
  - seed_load in IDLE: next lfsr = seed; a seed of 0 is replaced by SEED.
  - seed_load has priority over in_valid in the same cycle; in_ready=0 during that cycle.
- FSM states: IDLE, ALIGN, RUN, CAPT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: mask m=lfsr[3:0]; register X_s1<=m and X_s0<=in_data^m; go to ALIGN.
  - The mask is never taken from the same bits as Fresh.
- ALIGN:
  - Holds X_s0/X_s1 stable.
  - Waits for Synch=1, then goes to RUN.
  - Reason: a launch is allowed only at a window boundary, so the inputs are stable for a full LATENCY window.
- RUN:
  - Holds X.
  - On the next Synch=1, goes to CAPT.
  - The gated S-box output register loads at this boundary.
- CAPT:
  - One cycle.
  - out_data <= Y_s0^Y_s1, out_valid <= 1, then go to DONE.
  - Shares are recombined only in this cycle; X_s0/X_s1 are cleared to 0 here.
- DONE:
  - out_valid=1, out_data held.
  - On out_ready: out_valid=0, go to IDLE.
  - Back-to-back: out_ready and a new in_valid in the same cycle do not overlap; in_valid is taken on the following IDLE cycle.
- Total latency from accept to out_valid:
  - Minimum LATENCY+2 cycles, when Synch fires the cycle after accept.
  - Maximum 2*LATENCY+1 cycles.
- Timeout:
  - A cycle counter is cleared on entry to ALIGN and counts in ALIGN and RUN.
  - Once it reaches TIMEOUT: timeout_err<=1 (sticky until reset), out_data<=0, go to DONE.
- Synch while in IDLE, CAPT or DONE is ignored.
- Reset mid-operation: immediate return to reset values; any partial result is discarded.

Decomposition:
- Shared package skinny_masking_pkg holds:
  - state enum.
  - LFSR tap mask constant and default seed.
  - function sbox_ref(nibble), the unmasked Skinny S-box {c,6,9,0,1,a,2,b,3,8,5,d,4,e,7,f}, for bench and assertions.
- Natural sub-module: share_lfsr16 (LFSR with load and zero-seed guard).

Test Plan:
- Basic run: reset, then in_data=0x0 with the S-box attached -> out_valid within 2*LATENCY+1 cycles, out_data=0xC, timeout_err=0.
- Exhaustive sweep: send in_data=0x1..0xF back-to-back, out_ready held high -> outputs 6,9,0,1,A,2,B,3,8,5,D,4,E,7,F in order; X_s0^X_s1 equals in_data throughout ALIGN/RUN.
- Seeding:
  - seed_load with seed=0x0000 -> mask sequence matches a SEED-seeded model.
  - seed=0x1234 -> after accept, X_s1 equals bit-model lfsr[3:0] and Fresh changes each cycle.
- Backpressure: out_ready=0 for 7 cycles -> out_valid and out_data=0xF stay stable; in_ready=0 until the cycle after out_ready=1.
- Timeout: tie Synch=0, accept 0x5 -> exactly TIMEOUT cycles later timeout_err=1, out_valid=1, out_data=0; flag stays set after the next transaction.
- Reset mid-RUN: pull rst low while in RUN -> out_valid, X_s0, X_s1 and busy all 0 asynchronously; the next transaction 0x3 returns 0x0.
